// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl handshake monitor: per-channel latency/busy/stall statistics with a registered readout port.
// Optional feature macro: PERF_MON_SUM_EN adds a saturating per-channel latency-sum accumulator (rd_sel 6).
module ap_ctrl_perf_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LAT_W  = 24,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] mon_start,
  input  logic [NUM_CH-1:0] mon_ready,
  input  logic [NUM_CH-1:0] mon_done,
  input  logic [NUM_CH-1:0] mon_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [63:0]       rd_data,
  output logic              rd_valid,
  output logic              all_idle,
  output logic [NUM_CH-1:0] ovf
);

  localparam int unsigned RDY_W = (CNT_W < 32) ? CNT_W : 32;
  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [LAT_W-1:0] LAT_ONES = '1;
  localparam logic [RDY_W-1:0] RDY_ONES = '1;
`ifdef PERF_MON_SUM_EN
  localparam int unsigned SUM_W  = CNT_W + LAT_W;
  localparam int unsigned SUMX_W = SUM_W + 1;
  localparam logic [SUM_W-1:0] SUM_ONES = '1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_STALL  = 2'd2
  } state_t;

  logic [CNT_W-1:0] w_txn      [NUM_CH];
  logic [CNT_W-1:0] w_busy     [NUM_CH];
  logic [CNT_W-1:0] w_stall    [NUM_CH];
  logic [LAT_W-1:0] w_lat_last [NUM_CH];
  logic [LAT_W-1:0] w_lat_min  [NUM_CH];
  logic [LAT_W-1:0] w_lat_max  [NUM_CH];
  logic [63:0]      w_status   [NUM_CH];
`ifdef PERF_MON_SUM_EN
  logic [SUM_W-1:0] w_lat_sum  [NUM_CH];
`endif
  logic [NUM_CH-1:0] w_ovf;
  logic [NUM_CH-1:0] w_idle_nx;
  logic [63:0]       w_rd_mux;

  logic [63:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_all_idle;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           r_state, w_state_nx;
    logic [LAT_W-1:0] r_lc, w_lc_nx, w_lc_inc, w_rec_lat;
    logic             w_rec, w_busy_inc, w_stall_inc, w_rdy_inc, w_perr_set, w_lc_sat;
    logic [CNT_W-1:0] r_txn, r_busy, r_stall;
    logic [LAT_W-1:0] r_lat_last, r_lat_min, r_lat_max;
    logic [RDY_W-1:0] r_rdy;
    logic             r_perr, r_ovf, w_ovf_set, w_sum_sat;

    assign w_lc_inc  = (r_lc == LAT_ONES) ? r_lc : r_lc + LAT_W'(1);
    assign w_rdy_inc = (r_state == S_ACTIVE) && mon_ready[g];

    // Next state, latency counter and per-cycle statistic events
    always_comb begin
      w_state_nx  = r_state;
      w_lc_nx     = r_lc;
      w_rec       = 1'b0;
      w_rec_lat   = r_lc;
      w_busy_inc  = 1'b0;
      w_stall_inc = 1'b0;
      w_perr_set  = 1'b0;
      w_lc_sat    = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mon_start[g]) begin
            if (mon_done[g] && mon_continue[g]) begin
              w_rec     = 1'b1;
              w_rec_lat = LAT_W'(1);
            end else begin
              w_state_nx = S_ACTIVE;
              w_lc_nx    = LAT_W'(1);
            end
          end
        end
        S_ACTIVE: begin
          w_busy_inc = 1'b1;
          w_lc_nx    = w_lc_inc;
          w_lc_sat   = (r_lc == LAT_ONES);
          if (mon_done[g] && mon_continue[g]) begin
            w_rec     = 1'b1;
            w_rec_lat = w_lc_inc;
            if (mon_start[g]) w_lc_nx = LAT_W'(1);
            else              w_state_nx = S_IDLE;
          end else if (mon_done[g]) begin
            w_state_nx = S_STALL;
          end
        end
        S_STALL: begin
          w_stall_inc = 1'b1;
          if (mon_done[g] && mon_continue[g]) begin
            w_rec      = 1'b1;
            w_state_nx = S_IDLE;
          end else if (!mon_done[g]) begin
            // done dropped while output was still back-pressured
            w_perr_set = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_state <= S_IDLE;
        r_lc    <= '0;
      end else begin
        r_state <= w_state_nx;
        r_lc    <= w_lc_nx;
      end
    end

`ifdef PERF_MON_SUM_EN
    logic [SUM_W-1:0]  r_lat_sum;
    logic [SUMX_W-1:0] w_sum_add;
    assign w_sum_add = {1'b0, r_lat_sum} + SUMX_W'(w_rec_lat);
    assign w_sum_sat = w_rec && w_sum_add[SUM_W];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)                r_lat_sum <= '0;
      else if (clear)               r_lat_sum <= '0;
      else if (!finish && w_rec)    r_lat_sum <= w_sum_sat ? SUM_ONES : w_sum_add[SUM_W-1:0];
    end
    assign w_lat_sum[g] = r_lat_sum;
`else
    assign w_sum_sat = 1'b0;
`endif

    assign w_ovf_set = (w_rec && (r_txn == CNT_ONES)) || (w_busy_inc && (r_busy == CNT_ONES)) ||
                       (w_stall_inc && (r_stall == CNT_ONES)) || (w_rdy_inc && (r_rdy == RDY_ONES)) ||
                       w_lc_sat || w_sum_sat;

    // Statistics: clear beats freeze, freeze beats updates
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n || clear) begin
        r_txn      <= '0;
        r_busy     <= '0;
        r_stall    <= '0;
        r_lat_last <= '0;
        r_lat_min  <= LAT_ONES;
        r_lat_max  <= '0;
        r_rdy      <= '0;
        r_perr     <= 1'b0;
        r_ovf      <= 1'b0;
      end else if (!finish) begin
        if (w_rec) begin
          if (r_txn != CNT_ONES) r_txn <= r_txn + CNT_W'(1);
          r_lat_last <= w_rec_lat;
          if (w_rec_lat < r_lat_min) r_lat_min <= w_rec_lat;
          if (w_rec_lat > r_lat_max) r_lat_max <= w_rec_lat;
        end
        if (w_busy_inc && (r_busy != CNT_ONES))   r_busy  <= r_busy + CNT_W'(1);
        if (w_stall_inc && (r_stall != CNT_ONES)) r_stall <= r_stall + CNT_W'(1);
        if (w_rdy_inc && (r_rdy != RDY_ONES))     r_rdy   <= r_rdy + RDY_W'(1);
        if (w_perr_set) r_perr <= 1'b1;
        if (w_ovf_set)  r_ovf  <= 1'b1;
      end
    end

    assign w_txn[g]      = r_txn;
    assign w_busy[g]     = r_busy;
    assign w_stall[g]    = r_stall;
    assign w_lat_last[g] = r_lat_last;
    assign w_lat_min[g]  = r_lat_min;
    assign w_lat_max[g]  = r_lat_max;
    assign w_status[g]   = {32'(r_rdy), 28'd0, r_ovf, r_perr, 2'(r_state)};
    assign w_ovf[g]      = r_ovf;
    assign w_idle_nx[g]  = (w_state_nx == S_IDLE);
  end

  // Field/channel select; out-of-range channels read as zero
  always_comb begin
    w_rd_mux = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        3'd0:    w_rd_mux = 64'(w_txn[rd_ch]);
        3'd1:    w_rd_mux = 64'(w_lat_last[rd_ch]);
        3'd2:    w_rd_mux = 64'(w_lat_min[rd_ch]);
        3'd3:    w_rd_mux = 64'(w_lat_max[rd_ch]);
        3'd4:    w_rd_mux = 64'(w_busy[rd_ch]);
        3'd5:    w_rd_mux = 64'(w_stall[rd_ch]);
`ifdef PERF_MON_SUM_EN
        3'd6:    w_rd_mux = 64'(w_lat_sum[rd_ch]);
`else
        3'd6:    w_rd_mux = '0;
`endif
        default: w_rd_mux = w_status[rd_ch];
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_all_idle <= 1'b1;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
      r_all_idle <= &w_idle_nx;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign all_idle = r_all_idle;
  assign ovf      = w_ovf;

endmodule

// File: doc/ap_ctrl_perf_monitor.md
# ap_ctrl_perf_monitor

Synthesizable, parametrised multi-channel monitor for HLS `ap_ctrl` handshakes. It observes `ap_start`/`ap_ready`/`ap_done`/`ap_continue` of up to `NUM_CH` kernel instances. For each channel it accumulates transaction count, last/min/max latency, busy cycles and output-stall cycles in on-chip counters. It sits beside the kernels in the top-level wrapper, and a PS/AXI-lite shim reads its statistics through a registered channel/field readout port, so the same figures are available on hardware.

## Interface
- `NUM_CH`, 4: number of monitored channels (1..16).
- `CNT_W`, 32: width of the transaction, busy and stall counters.
- `LAT_W`, 24: width of the latency registers.
- `ap_clk` in 1: sole clock; all inputs sampled on its rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `mon_start` in `NUM_CH`: per-channel `ap_start`.
- `mon_ready` in `NUM_CH`: per-channel `ap_ready` (used for the ready count only).
- `mon_done` in `NUM_CH`: per-channel `ap_done`.
- `mon_continue` in `NUM_CH`: per-channel `ap_continue`; tie high for `ap_ctrl_hs` kernels.
- `finish` in 1: freeze request; while high, all statistics hold their values.
- `clear` in 1: synchronous pulse; returns all statistics to their reset values.
- `rd_en` in 1: readout request.
- `rd_ch` in `$clog2(NUM_CH)`: channel select.
- `rd_sel` in 3: field select; 0 = txn, 1 = lat_last, 2 = lat_min, 3 = lat_max, 4 = busy, 5 = stall, 6 = lat_sum, 7 = status.
- `rd_data` out 64: selected field, zero-extended.
- `rd_valid` out 1: one-cycle pulse marking `rd_data` valid.
- `all_idle` out 1: every channel is in IDLE.
- `ovf` out `NUM_CH`: sticky per-channel saturation flag.

## Operation
- Each channel runs an independent three-state FSM: IDLE, ACTIVE, STALL.
- **IDLE**
  - If `start` is high: go to ACTIVE and load the latency counter `lc` with 1.
  - If `start`, `done` and `continue` are all high in the same cycle: record a latency of 1 and stay in IDLE.
- **ACTIVE**
  - `lc` increments every cycle and `busy` increments every cycle.
  - `done && continue`: record `lc+1` and go to IDLE. If `start` is also high, instead stay in ACTIVE with `lc` = 1 (back-to-back transaction).
  - `done && !continue`: go to STALL.
- **STALL**
  - `stall` increments every cycle; `lc` is frozen.
  - `done && continue`: record `lc` and go to IDLE.
  - `done` falling without `continue` is a protocol error: set status bit 2 and go to IDLE without recording.
- **Record**
  - `txn` increments by 1 and `lat_last` takes the recorded value `L`.
  - `lat_min = min(lat_min, L)` and `lat_max = max(lat_max, L)`.
- **Ready count:** `ready` pulses while in ACTIVE go to a hidden counter that is exposed as `status[63:32]`.
- **Saturation**
  - Every counter saturates at all-ones and sets `ovf[ch]`.
  - `lc` saturates at `2^LAT_W-1`.
- **Freeze:** while `finish` is high, the FSMs keep tracking but no statistic register is written. This matches the end-of-sim dump point.
- **Status word:** `status[1:0]` = FSM state (0 IDLE, 1 ACTIVE, 2 STALL), bit 2 = protocol error, bit 3 = `ovf`.

## Timing
- Reset values:
  - All counters, `lat_last`, `rd_data`, `rd_valid` and `ovf` are 0.
  - `lat_min` is all-ones.
  - Every FSM is in IDLE, so `all_idle` is 1.
- Statistics are updated on the clock edge that samples the event, so they are visible one cycle later.
- Readout latency is 1 cycle: `rd_en` sampled at edge N gives `rd_data`/`rd_valid` after edge N. `rd_data` holds until the next `rd_en`.
- An out-of-range `rd_ch` returns 0 with `rd_valid` still pulsed.
- `clear` together with a record in the same cycle: `clear` wins, and the FSM state is preserved.
- `finish` together with `clear`: `clear` wins.
- Asserting `ap_rst_n` mid-transaction aborts it immediately; nothing is recorded.

## Configuration
- `PERF_MON_SUM_EN`
  - Defined: each channel has a `CNT_W+LAT_W`-bit saturating `lat_sum` accumulator, updated on every record and read at `rd_sel`=6.
  - Undefined: the accumulator is not instantiated and `rd_sel`=6 returns 0.

## Test plan
- **Single transaction:** `start` at cycle 0, `done`+`continue` at cycle 9 -> txn=1, lat_last=lat_min=lat_max=10, busy=9, stall=0.
- **Stall:** `done` high from cycle 5, `continue` low for 4 cycles, then high -> lat=6, stall=4, status state=STALL during the hold.
- **Back-to-back:** 3 transactions of latencies 4/7/5 with overlapping `start`/`done` -> txn=3, min=4, max=7, lat_sum=16 when `PERF_MON_SUM_EN` is defined, else 0.
- **Freeze and clear:** `finish` high, then 2 more transactions -> txn unchanged. Then pulse `clear` -> txn=0, lat_min=all-ones, `all_idle` tracks the FSMs.
- **Saturation:** `CNT_W`=4 and 17 transactions -> txn=15, `ovf[ch]`=1, status bit 3 set.
- **Reset mid-run:** assert `ap_rst_n` low in ACTIVE on channel 2 -> all outputs return to reset values asynchronously. The next transaction records a correct latency.
